// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES types, round counts and round-transform helpers
package aes_pkg;

  typedef enum logic [1:0] {
    KEYLEN_128  = 2'd0,
    KEYLEN_192  = 2'd1,
    KEYLEN_256  = 2'd2,
    KEYLEN_RSVD = 2'd3
  } keylen_e;

  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_192 = 4'd12;
  localparam logic [3:0] NR_256 = 4'd14;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_SBOX,
    ST_MAIN,
    ST_FINAL
  } enc_state_e;

  typedef enum logic [1:0] {
    DP_INIT,
    DP_MAIN,
    DP_FINAL
  } dp_mode_e;

  // The reserved code runs as AES-256.
  function automatic logic [3:0] rounds_for(input logic [1:0] kl);
    case (kl)
      KEYLEN_128: return NR_128;
      KEYLEN_192: return NR_192;
      default:    return NR_256;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
  endfunction

  function automatic logic [31:0] mixw(input logic [31:0] w);
    logic [7:0] b0, b1, b2, b3;
    {b0, b1, b2, b3} = w;
    return {xtime(b0) ^ xtime(b1) ^ b1 ^ b2 ^ b3,
            b0 ^ xtime(b1) ^ xtime(b2) ^ b2 ^ b3,
            b0 ^ b1 ^ xtime(b2) ^ xtime(b3) ^ b3,
            xtime(b0) ^ b0 ^ b1 ^ b2 ^ xtime(b3)};
  endfunction

  function automatic logic [127:0] mixcolumns(input logic [127:0] s);
    return {mixw(s[127:96]), mixw(s[95:64]), mixw(s[63:32]), mixw(s[31:0])};
  endfunction

  // Row r of column c comes from column (c + r) mod 4.
  function automatic logic [127:0] shiftrows(input logic [127:0] s);
    logic [31:0] w0, w1, w2, w3;
    {w0, w1, w2, w3} = s;
    return {w0[31:24], w1[23:16], w2[15:8], w3[7:0],
            w1[31:24], w2[23:16], w3[15:8], w0[7:0],
            w2[31:24], w3[23:16], w0[15:8], w1[7:0],
            w3[31:24], w0[23:16], w1[15:8], w2[7:0]};
  endfunction

endpackage

// File: rtl/aes_enc_round_dp.sv
// rtl/aes_enc_round_dp.sv - combinational encipher round transforms
module aes_enc_round_dp
  import aes_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] round_key,
  input  dp_mode_e     mode,
  output logic [127:0] next_state
);

  always_comb begin
    next_state = '0;
    case (mode)
      DP_INIT: next_state = state ^ round_key;
      DP_MAIN: next_state = mixcolumns(shiftrows(state)) ^ round_key;
      default: next_state = shiftrows(state) ^ round_key;
    endcase
  end

endmodule

// File: rtl/aes_encipher_engine.sv
// rtl/aes_encipher_engine.sv - AES-128/192/256 encipher round engine with S parallel S-box words
module aes_encipher_engine
  import aes_pkg::*;
#(
  parameter int SBOX_WORDS = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    next,
  input  logic [1:0]              keylen,
  output logic [3:0]              round,
  input  logic [127:0]            round_key,
  output logic [32*SBOX_WORDS-1:0] sboxw,
  input  logic [32*SBOX_WORDS-1:0] new_sboxw,
  input  logic [127:0]            block,
  output logic [127:0]            new_block,
  output logic                    ready,
  output logic                    done
);

  localparam int W   = 32 * SBOX_WORDS;
  localparam int SWN = 4 / SBOX_WORDS;
  localparam int SWB = (SWN > 1) ? $clog2(SWN) : 1;
  localparam logic [SWB-1:0] SW_LAST = SWB'(SWN - 1);

  if (!(SBOX_WORDS == 1 || SBOX_WORDS == 2 || SBOX_WORDS == 4)) begin : g_bad_sbox_words
    $error("SBOX_WORDS must be 1, 2 or 4");
  end

  enc_state_e     fsm;
  logic [3:0]     round_ctr;
  logic [3:0]     nr;
  logic [SWB-1:0] sword_ctr;
  logic [6:0]     sel_hi;
  dp_mode_e       dp_mode;
  logic [127:0]   dp_state;

  assign round  = round_ctr;
  assign sel_hi = 7'(127 - W * int'(sword_ctr));
  assign sboxw  = (fsm == ST_SBOX) ? new_block[sel_hi -: W] : '0;

  always_comb begin
    dp_mode = DP_FINAL;
    case (fsm)
      ST_INIT: dp_mode = DP_INIT;
      ST_MAIN: dp_mode = DP_MAIN;
      default: ;
    endcase
  end

  aes_enc_round_dp u_dp (
    .state      (new_block),
    .round_key  (round_key),
    .mode       (dp_mode),
    .next_state (dp_state)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm       <= ST_IDLE;
      round_ctr <= '0;
      nr        <= NR_128;
      sword_ctr <= '0;
      new_block <= '0;
      ready     <= 1'b1;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (fsm)
        ST_IDLE: begin
          if (next) begin
            new_block <= block;
            nr        <= rounds_for(keylen);
            round_ctr <= '0;
            ready     <= 1'b0;
            fsm       <= ST_INIT;
          end
        end
        ST_INIT: begin
          new_block <= dp_state;
          round_ctr <= 4'd1;
          sword_ctr <= '0;
          fsm       <= ST_SBOX;
        end
        ST_SBOX: begin
          new_block[sel_hi -: W] <= new_sboxw;
          if (sword_ctr == SW_LAST) begin
            sword_ctr <= '0;
            fsm       <= (round_ctr < nr) ? ST_MAIN : ST_FINAL;
          end else begin
            sword_ctr <= sword_ctr + SWB'(1);
          end
        end
        ST_MAIN: begin
          new_block <= dp_state;
          round_ctr <= round_ctr + 4'd1;
          sword_ctr <= '0;
          fsm       <= ST_SBOX;
        end
        ST_FINAL: begin
          new_block <= dp_state;
          ready     <= 1'b1;
          done      <= 1'b1;
          fsm       <= ST_IDLE;
        end
        default: fsm <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_encipher_engine.sv
// tb/tb_aes_encipher_engine.sv - directed FIPS-197 vectors on S=1, S=2 and S=4 engines
module tb_aes_encipher_engine;

  localparam logic [2047:0] SBOX_TAB = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] KEY128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KEY192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] KEYB   = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [127:0] PTB    = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CTB    = 128'h3925841d02dc09fbdc118597196a0b32;

  logic          clk;
  logic          reset;
  logic          next_v      [3];
  logic [1:0]    keylen_v    [3];
  logic [3:0]    round_v     [3];
  logic [127:0]  rk_v        [3];
  logic [127:0]  block_v     [3];
  logic [127:0]  new_block_v [3];
  logic          ready_v     [3];
  logic          done_v      [3];
  logic [2047:0] rks_v       [3];
  logic [31:0]   sboxw_s1, new_sboxw_s1;
  logic [63:0]   sboxw_s2, new_sboxw_s2;
  logic [127:0]  sboxw_s4, new_sboxw_s4;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TAB[2047 - 8 * int'(b) -: 8];
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Bench key memory: round key r lives at bits 2047-128r downward.
  function automatic logic [2047:0] expand_key(input logic [255:0] key, input int nk);
    logic [31:0]   w [60];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [2047:0] res;
    int            nr;
    nr  = nk + 6;
    rc  = 8'h01;
    res = '0;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32 * i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i - 1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i - nk] ^ t;
    end
    for (int r = 0; r <= nr; r++)
      res[2047 - 128 * r -: 128] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    return res;
  endfunction

  assign rk_v[0] = rks_v[0][2047 - 128 * int'(round_v[0]) -: 128];
  assign rk_v[1] = rks_v[1][2047 - 128 * int'(round_v[1]) -: 128];
  assign rk_v[2] = rks_v[2][2047 - 128 * int'(round_v[2]) -: 128];

  assign new_sboxw_s1 = subw(sboxw_s1);
  assign new_sboxw_s2 = {subw(sboxw_s2[63:32]), subw(sboxw_s2[31:0])};
  assign new_sboxw_s4 = {subw(sboxw_s4[127:96]), subw(sboxw_s4[95:64]),
                         subw(sboxw_s4[63:32]), subw(sboxw_s4[31:0])};

  aes_encipher_engine #(.SBOX_WORDS(1)) u_s1 (
    .clk(clk), .reset(reset), .next(next_v[0]), .keylen(keylen_v[0]),
    .round(round_v[0]), .round_key(rk_v[0]), .sboxw(sboxw_s1), .new_sboxw(new_sboxw_s1),
    .block(block_v[0]), .new_block(new_block_v[0]), .ready(ready_v[0]), .done(done_v[0]));

  aes_encipher_engine #(.SBOX_WORDS(2)) u_s2 (
    .clk(clk), .reset(reset), .next(next_v[1]), .keylen(keylen_v[1]),
    .round(round_v[1]), .round_key(rk_v[1]), .sboxw(sboxw_s2), .new_sboxw(new_sboxw_s2),
    .block(block_v[1]), .new_block(new_block_v[1]), .ready(ready_v[1]), .done(done_v[1]));

  aes_encipher_engine #(.SBOX_WORDS(4)) u_s4 (
    .clk(clk), .reset(reset), .next(next_v[2]), .keylen(keylen_v[2]),
    .round(round_v[2]), .round_key(rk_v[2]), .sboxw(sboxw_s4), .new_sboxw(new_sboxw_s4),
    .block(block_v[2]), .new_block(new_block_v[2]), .ready(ready_v[2]), .done(done_v[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // mode 1: change keylen/block mid-run; mode 2: pulse next while busy.
  task automatic run_op(input int d, input logic [1:0] kl, input logic [127:0] pt, input int mode,
                        output int lat, output int dones, output logic [3:0] max_round,
                        output logic [127:0] ct);
    @(negedge clk);
    keylen_v[d] = kl;
    block_v[d]  = pt;
    next_v[d]   = 1'b1;
    @(negedge clk);
    next_v[d] = 1'b0;
    lat = 0;
    dones = 0;
    max_round = '0;
    while (!ready_v[d] && lat < 300) begin
      if (done_v[d]) dones++;
      if (round_v[d] > max_round) max_round = round_v[d];
      if (mode == 1 && lat == 3) begin
        keylen_v[d] = 2'd0;
        block_v[d]  = '0;
      end
      if (mode == 2 && lat == 10) next_v[d] = 1'b1;
      if (mode == 2 && lat == 11) next_v[d] = 1'b0;
      lat++;
      @(negedge clk);
    end
    ct = new_block_v[d];
    if (done_v[d]) dones++;
    repeat (3) begin
      @(negedge clk);
      if (done_v[d]) dones++;
    end
  endtask

  initial begin
    int           lat, dones;
    logic [3:0]   mr;
    logic [127:0] ct;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next_v[i]   = 1'b0;
      keylen_v[i] = 2'd0;
      block_v[i]  = '0;
      rks_v[i]    = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_ready%0d", i), 128'(ready_v[i]), 128'd1);
      check($sformatf("rst_done%0d", i), 128'(done_v[i]), 128'd0);
      check($sformatf("rst_block%0d", i), new_block_v[i], 128'd0);
      check($sformatf("rst_round%0d", i), 128'(round_v[i]), 128'd0);
    end
    check("rst_sboxw", 128'(sboxw_s1), 128'd0);

    rks_v[0] = expand_key(KEY128, 4);
    run_op(0, 2'd0, PT, 0, lat, dones, mr, ct);
    check("aes128_s1_ct", ct, CT128);
    check("aes128_s1_lat", 128'(lat), 128'd51);
    check("aes128_s1_done", 128'(dones), 128'd1);

    rks_v[0] = expand_key(KEY192, 6);
    run_op(0, 2'd1, PT, 0, lat, dones, mr, ct);
    check("aes192_s1_ct", ct, CT192);
    check("aes192_s1_lat", 128'(lat), 128'd61);
    check("aes192_s1_maxround", 128'(mr), 128'd12);

    rks_v[1] = expand_key(KEY192, 6);
    run_op(1, 2'd1, PT, 0, lat, dones, mr, ct);
    check("aes192_s2_ct", ct, CT192);
    check("aes192_s2_lat", 128'(lat), 128'd37);
    check("aes192_s2_maxround", 128'(mr), 128'd12);

    rks_v[1] = expand_key(KEY256, 8);
    run_op(1, 2'd2, PT, 0, lat, dones, mr, ct);
    check("aes256_s2_ct", ct, CT256);
    check("aes256_s2_lat", 128'(lat), 128'd43);

    rks_v[2] = expand_key(KEY256, 8);
    run_op(2, 2'd2, PT, 1, lat, dones, mr, ct);
    check("aes256_s4_ct", ct, CT256);
    check("aes256_s4_lat", 128'(lat), 128'd29);
    check("aes256_s4_maxround", 128'(mr), 128'd14);

    rks_v[0] = expand_key(KEY128, 4);
    run_op(0, 2'd0, PT, 2, lat, dones, mr, ct);
    check("busy_ct", ct, CT128);
    check("busy_lat", 128'(lat), 128'd51);
    check("busy_done", 128'(dones), 128'd1);
    check("busy_no_queue", 128'(ready_v[0]), 128'd1);

    rks_v[2] = expand_key(KEY128, 4);
    @(negedge clk);
    keylen_v[2] = 2'd0;
    block_v[2]  = PT;
    next_v[2]   = 1'b1;
    @(negedge clk);
    lat = 0;
    while (!done_v[2] && lat < 100) begin
      lat++;
      @(negedge clk);
    end
    check("b2b_lat1", 128'(lat), 128'd21);
    check("b2b_ct1", new_block_v[2], CT128);
    rks_v[2]   = expand_key(KEYB, 4);
    block_v[2] = PTB;
    @(negedge clk);
    check("b2b_accept", 128'(ready_v[2]), 128'd0);
    check("b2b_latched", new_block_v[2], PTB);
    lat = 0;
    while (!done_v[2] && lat < 100) begin
      lat++;
      @(negedge clk);
    end
    next_v[2] = 1'b0;
    check("b2b_lat2", 128'(lat), 128'd21);
    check("b2b_ct2", new_block_v[2], CTB);
    @(negedge clk);
    check("b2b_idle", 128'(ready_v[2]), 128'd1);

    rks_v[0] = expand_key(KEY128, 4);
    @(negedge clk);
    keylen_v[0] = 2'd0;
    block_v[0]  = PT;
    next_v[0]   = 1'b1;
    @(negedge clk);
    next_v[0] = 1'b0;
    lat = 0;
    while (round_v[0] != 4'd5 && lat < 200) begin
      lat++;
      @(negedge clk);
    end
    check("midrst_round5", 128'(round_v[0]), 128'd5);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_ready", 128'(ready_v[0]), 128'd1);
    check("midrst_done", 128'(done_v[0]), 128'd0);
    check("midrst_block", new_block_v[0], 128'd0);
    check("midrst_round", 128'(round_v[0]), 128'd0);
    run_op(0, 2'd0, PT, 0, lat, dones, mr, ct);
    check("postrst_ct", ct, CT128);
    check("postrst_lat", 128'(lat), 128'd51);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
